pc_phase_ctrl: RTL and testbench

PC_PHASE_CTRL -- requirements
Module: pc_phase_ctrl

---
 rtl/cpu_pkg.sv | 25 ++
 rtl/phase_ring.sv | 36 +++
 rtl/pc_phase_ctrl.sv | 92 +++++++++
 tb/tb_pc_phase_ctrl.sv | 226 ++++++++++++++++++++++
 4 files changed

// File: rtl/cpu_pkg.sv
// Shared CPU definitions: PC width, one-hot phase constants and FSM state encoding.
package cpu_pkg;

  localparam int unsigned PC_W  = 12;
  localparam int unsigned PH_W  = 5;
  localparam int unsigned RET_W = 16;

  localparam logic [PH_W-1:0] PH_FETCH  = 5'b00001;
  localparam logic [PH_W-1:0] PH_DECODE = 5'b00010;
  localparam logic [PH_W-1:0] PH_EXEC   = 5'b00100;
  localparam logic [PH_W-1:0] PH_MEM    = 5'b01000;
  localparam logic [PH_W-1:0] PH_WB     = 5'b10000;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'b00,
    ST_RUN    = 2'b01,
    ST_HALTED = 2'b10
  } cpu_state_e;

  // Advance one phase in the fetch..writeback cycle; WB wraps back to FETCH.
  function automatic logic [PH_W-1:0] rotate_phase(input logic [PH_W-1:0] ph);
    return {ph[PH_W-2:0], ph[PH_W-1]};
  endfunction

endpackage

// File: rtl/phase_ring.sv
// One-hot execution phase rotator; all-zero whenever the core is not running.
module phase_ring
  import cpu_pkg::*;
(
  input  logic            clk,
  input  logic            rst,
  input  logic            run,
  input  logic            ring_start,
  output logic [PH_W-1:0] phase
);

  logic [PH_W-1:0] phase_d;
  logic [PH_W-1:0] phase_q;

  // Next phase: restart at FETCH on entry to RUN, rotate while running, else clear.
  always_comb begin
    phase_d = '0;
    if (ring_start) begin
      phase_d = PH_FETCH;
    end else if (run) begin
      phase_d = rotate_phase(phase_q);
    end
  end

  // Phase register with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      phase_q <= '0;
    end else begin
      phase_q <= phase_d;
    end
  end

  assign phase = phase_q;

endmodule

// File: rtl/pc_phase_ctrl.sv
// Program counter, run/halt FSM and retired-instruction counter for the core.
module pc_phase_ctrl
  import cpu_pkg::*;
(
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             halt_req,
  input  logic             load_pc,
  input  logic [PC_W-1:0]  load_addr,
  input  logic [PC_W-1:0]  next_pc,
  input  logic             pc_enable,
  output logic [PH_W-1:0]  phase,
  output logic [PC_W-1:0]  pc,
  output logic [PC_W-1:0]  pc_plus1,
  output logic             running,
  output logic [RET_W-1:0] retired
);

  cpu_state_e       state_d, state_q;
  logic [PC_W-1:0]  pc_d, pc_q;
  logic [RET_W-1:0] retired_d, retired_q;
  logic             in_run;
  logic             wb_cycle;
  logic             ring_run;
  logic             ring_start;

  assign in_run   = (state_q == ST_RUN);
  assign wb_cycle = in_run && (phase == PH_WB);

  // FSM next state: start leaves IDLE/HALTED, a WB-phase halt leaves RUN.
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE:   if (start) state_d = ST_RUN;
      ST_RUN:    if (wb_cycle && halt_req) state_d = ST_HALTED;
      ST_HALTED: if (start) state_d = ST_RUN;
      default:   state_d = ST_IDLE;
    endcase
  end

  // Ring is driven from the next state so phase reads FETCH on the first RUN cycle.
  always_comb begin
    ring_run   = (state_d == ST_RUN);
    ring_start = (state_q != ST_RUN) && (state_d == ST_RUN);
  end

  // PC update: selector writes only in RUN, external loads only outside RUN.
  always_comb begin
    pc_d = pc_q;
    if (in_run) begin
      if (pc_enable) pc_d = next_pc;
    end else if (load_pc) begin
      pc_d = load_addr;
    end
  end

  // Retire counter: one per completed WB phase, saturating at all-ones.
  always_comb begin
    retired_d = retired_q;
    if (wb_cycle && (retired_q != '1)) begin
      retired_d = retired_q + 16'd1;
    end
  end

  // State, PC and retire registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= ST_IDLE;
      pc_q      <= '0;
      retired_q <= '0;
    end else begin
      state_q   <= state_d;
      pc_q      <= pc_d;
      retired_q <= retired_d;
    end
  end

  phase_ring u_phase_ring (
    .clk        (clk),
    .rst        (rst),
    .run        (ring_run),
    .ring_start (ring_start),
    .phase      (phase)
  );

  assign pc       = pc_q;
  assign pc_plus1 = pc_q + 12'd1;
  assign running  = in_run;
  assign retired  = retired_q;

endmodule

// File: tb/tb_pc_phase_ctrl.sv
// Self-checking bench for pc_phase_ctrl with an abstract cycle model.
module tb_pc_phase_ctrl;

  logic        clk = 1'b0;
  logic        rst, start, halt_req, load_pc, pc_enable;
  logic [11:0] load_addr, next_pc;
  logic [4:0]  phase;
  logic [11:0] pc, pc_plus1;
  logic        running;
  logic [15:0] retired;

  int n_checks = 0;
  int n_pass   = 0;

  // Model: running flag, phase index 0..4, pc and retired count as plain integers.
  bit m_run = 1'b0;
  int m_ph  = 0;
  int m_pc  = 0;
  int m_ret = 0;

  pc_phase_ctrl dut (
    .clk       (clk),
    .rst       (rst),
    .start     (start),
    .halt_req  (halt_req),
    .load_pc   (load_pc),
    .load_addr (load_addr),
    .next_pc   (next_pc),
    .pc_enable (pc_enable),
    .phase     (phase),
    .pc        (pc),
    .pc_plus1  (pc_plus1),
    .running   (running),
    .retired   (retired)
  );

  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1);
  end

  function automatic logic [4:0] m_phase();
    return m_run ? 5'(1 << m_ph) : 5'd0;
  endfunction

  // One clock: drive inputs, advance the model at the edge, return at negedge.
  task automatic cyc(input logic r, input logic s, input logic h, input logic l,
                     input logic [11:0] la, input logic [11:0] na, input logic pe);
    rst = r; start = s; halt_req = h; load_pc = l;
    load_addr = la; next_pc = na; pc_enable = pe;
    @(posedge clk);
    if (r) begin
      m_run = 0; m_ph = 0; m_pc = 0; m_ret = 0;
    end else if (m_run) begin
      if (pe) m_pc = int'(na);
      if (m_ph == 4) begin
        if (m_ret < 65535) m_ret = m_ret + 1;
        if (h) m_run = 0;
        else m_ph = 0;
      end else begin
        m_ph = m_ph + 1;
      end
    end else begin
      if (l) m_pc = int'(la);
      if (s) begin m_run = 1; m_ph = 0; end
    end
    @(negedge clk);
  endtask

  task automatic adv(input int tgt);
    int n = 0;
    while (!(m_run && m_ph == tgt) && n < 12) begin
      cyc(0, 0, 0, 0, 12'h0, 12'h0, 0);
      n++;
    end
    n_checks++;
    if (phase !== 5'(1 << tgt)) $display("FAIL adv_phase: got %b want %b", phase, 5'(1 << tgt));
    else n_pass++;
  endtask

  task automatic test_reset();
    cyc(1, 1, 1, 1, 12'h123, 12'h456, 1);
    n_checks++; if (phase !== 5'b00000) $display("FAIL rst_phase: got %b want 00000", phase); else n_pass++;
    n_checks++; if (pc !== 12'h000) $display("FAIL rst_pc: got %h want 000", pc); else n_pass++;
    n_checks++; if (retired !== 16'h0000) $display("FAIL rst_retired: got %h want 0000", retired); else n_pass++;
    n_checks++; if (running !== 1'b0) $display("FAIL rst_running: got %b want 0", running); else n_pass++;
    n_checks++; if (pc_plus1 !== 12'h001) $display("FAIL rst_pc_plus1: got %h want 001", pc_plus1); else n_pass++;
  endtask

  task automatic test_fetch_seq();
    cyc(1, 0, 0, 0, 12'h0, 12'h0, 0);
    cyc(0, 1, 0, 0, 12'h0, 12'h0, 0);
    for (int k = 0; k < 3; k++) begin
      for (int p = 0; p < 5; p++) begin
        n_checks++;
        if (phase !== 5'(1 << p)) $display("FAIL seq_phase: got %b want %b", phase, 5'(1 << p)); else n_pass++;
        n_checks++;
        if (pc !== 12'((p == 0) ? k : k + 1)) $display("FAIL seq_pc: got %h want %h", pc, 12'((p == 0) ? k : k + 1)); else n_pass++;
        n_checks++;
        if (retired !== 16'(k)) $display("FAIL seq_retired: got %h want %h", retired, 16'(k)); else n_pass++;
        cyc(0, 0, 0, 0, 12'h0, 12'((m_pc + 1) % 4096), (p == 0));
      end
    end
    n_checks++; if (retired !== 16'd3) $display("FAIL seq_retired_end: got %h want 0003", retired); else n_pass++;
  endtask

  task automatic test_wrap();
    cyc(1, 0, 0, 0, 12'h0, 12'h0, 0);
    cyc(0, 0, 0, 1, 12'hFFF, 12'h0, 0);
    n_checks++; if (pc !== 12'hFFF) $display("FAIL wrap_load: got %h want fff", pc); else n_pass++;
    n_checks++; if (pc_plus1 !== 12'h000) $display("FAIL wrap_plus1: got %h want 000", pc_plus1); else n_pass++;
    cyc(0, 1, 0, 0, 12'h0, 12'h0, 0);
    n_checks++; if (phase !== 5'b00001) $display("FAIL wrap_start_phase: got %b want 00001", phase); else n_pass++;
    cyc(0, 0, 0, 0, 12'h0, 12'h000, 1);
    n_checks++; if (pc !== 12'h000) $display("FAIL wrap_fetch_pc: got %h want 000", pc); else n_pass++;
    n_checks++; if (phase !== 5'b00010) $display("FAIL wrap_fetch_phase: got %b want 00010", phase); else n_pass++;
  endtask

  task automatic test_load_start();
    cyc(1, 0, 0, 0, 12'h0, 12'h0, 0);
    cyc(0, 1, 0, 1, 12'h3C5, 12'h0, 0);
    n_checks++; if (pc !== 12'h3C5) $display("FAIL ldst_pc: got %h want 3c5", pc); else n_pass++;
    n_checks++; if (phase !== 5'b00001) $display("FAIL ldst_phase: got %b want 00001", phase); else n_pass++;
  endtask

  task automatic test_branch();
    adv(4);
    cyc(0, 0, 0, 0, 12'h0, 12'h2A0, 1);
    n_checks++; if (pc !== 12'h2A0) $display("FAIL branch_pc: got %h want 2a0", pc); else n_pass++;
    n_checks++; if (phase !== 5'b00001) $display("FAIL branch_phase: got %b want 00001", phase); else n_pass++;
  endtask

  task automatic test_halt_resume();
    int r0;
    adv(4);
    r0 = m_ret;
    cyc(0, 0, 1, 0, 12'h0, 12'h050, 1);
    n_checks++; if (pc !== 12'h050) $display("FAIL halt_pc: got %h want 050", pc); else n_pass++;
    n_checks++; if (phase !== 5'b00000) $display("FAIL halt_phase: got %b want 00000", phase); else n_pass++;
    n_checks++; if (running !== 1'b0) $display("FAIL halt_running: got %b want 0", running); else n_pass++;
    n_checks++; if (retired !== 16'(r0 + 1)) $display("FAIL halt_retired: got %h want %h", retired, 16'(r0 + 1)); else n_pass++;
    cyc(0, 0, 1, 0, 12'h0, 12'h777, 1);
    cyc(0, 0, 0, 0, 12'h0, 12'h666, 1);
    n_checks++; if (pc !== 12'h050) $display("FAIL halted_hold_pc: got %h want 050", pc); else n_pass++;
    cyc(0, 1, 0, 0, 12'h0, 12'h0, 0);
    n_checks++; if (phase !== 5'b00001) $display("FAIL resume_phase: got %b want 00001", phase); else n_pass++;
    n_checks++; if (pc !== 12'h050) $display("FAIL resume_pc: got %h want 050", pc); else n_pass++;
    n_checks++; if (retired !== 16'(r0 + 1)) $display("FAIL resume_retired: got %h want %h", retired, 16'(r0 + 1)); else n_pass++;
  endtask

  task automatic test_ignored();
    logic [11:0] pc0;
    adv(2);
    pc0 = 12'(m_pc);
    cyc(0, 0, 1, 0, 12'h0, 12'h0, 0);
    n_checks++; if (running !== 1'b1) $display("FAIL ign_halt_running: got %b want 1", running); else n_pass++;
    n_checks++; if (phase !== 5'b01000) $display("FAIL ign_halt_phase: got %b want 01000", phase); else n_pass++;
    cyc(0, 1, 0, 1, 12'hABC, 12'h0, 0);
    n_checks++; if (pc !== pc0) $display("FAIL ign_load_pc: got %h want %h", pc, pc0); else n_pass++;
    n_checks++; if (phase !== 5'b10000) $display("FAIL ign_start_phase: got %b want 10000", phase); else n_pass++;
  endtask

  task automatic test_mid_reset();
    adv(3);
    cyc(1, 1, 1, 0, 12'h0, 12'h5A5, 1);
    n_checks++; if (pc !== 12'h000) $display("FAIL midrst_pc: got %h want 000", pc); else n_pass++;
    n_checks++; if (retired !== 16'h0000) $display("FAIL midrst_retired: got %h want 0000", retired); else n_pass++;
    n_checks++; if (phase !== 5'b00000) $display("FAIL midrst_phase: got %b want 00000", phase); else n_pass++;
    n_checks++; if (running !== 1'b0) $display("FAIL midrst_running: got %b want 0", running); else n_pass++;
  endtask

  task automatic test_saturation();
    cyc(0, 1, 0, 0, 12'h0, 12'h0, 0);
    adv(1);
    force dut.retired_q = 16'hFFFF;
    m_ret = 65535;
    cyc(0, 0, 0, 0, 12'h0, 12'h0, 0);
    release dut.retired_q;
    cyc(0, 0, 0, 0, 12'h0, 12'h0, 0);
    n_checks++; if (retired !== 16'hFFFF) $display("FAIL sat_preload: got %h want ffff", retired); else n_pass++;
    adv(4);
    cyc(0, 0, 0, 0, 12'h0, 12'h0, 0);
    n_checks++; if (retired !== 16'hFFFF) $display("FAIL sat_hold: got %h want ffff", retired); else n_pass++;
    n_checks++; if (phase !== 5'b00001) $display("FAIL sat_phase: got %b want 00001", phase); else n_pass++;
  endtask

  task automatic test_random();
    logic r, s, h, l, pe;
    cyc(1, 0, 0, 0, 12'h0, 12'h0, 0);
    for (int i = 0; i < 600; i++) begin
      r  = ($urandom_range(0, 63) == 0);
      s  = ($urandom_range(0, 3) == 0);
      h  = ($urandom_range(0, 2) == 0);
      l  = ($urandom_range(0, 3) == 0);
      pe = ($urandom_range(0, 1) == 0);
      cyc(r, s, h, l, 12'($urandom_range(0, 4095)), 12'($urandom_range(0, 4095)), pe);
      n_checks++; if (phase !== m_phase()) $display("FAIL rnd_phase: got %b want %b", phase, m_phase()); else n_pass++;
      n_checks++; if (pc !== 12'(m_pc)) $display("FAIL rnd_pc: got %h want %h", pc, 12'(m_pc)); else n_pass++;
      n_checks++; if (pc_plus1 !== 12'((m_pc + 1) % 4096)) $display("FAIL rnd_pc_plus1: got %h want %h", pc_plus1, 12'((m_pc + 1) % 4096)); else n_pass++;
      n_checks++; if (running !== m_run) $display("FAIL rnd_running: got %b want %b", running, m_run); else n_pass++;
      n_checks++; if (retired !== 16'(m_ret)) $display("FAIL rnd_retired: got %h want %h", retired, 16'(m_ret)); else n_pass++;
    end
  endtask

  initial begin
    rst = 1'b1; start = 1'b0; halt_req = 1'b0; load_pc = 1'b0;
    load_addr = '0; next_pc = '0; pc_enable = 1'b0;
    @(negedge clk);
    test_reset();
    test_fetch_seq();
    test_wrap();
    test_load_start();
    test_branch();
    test_halt_resume();
    test_ignored();
    test_mid_reset();
    test_saturation();
    test_random();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
